// File: rtl/sdq_queue_ctrl_if.sv
// Handshake bundle between the SDQ queue controller and its producer/consumer.
//   enq_valid/enq_ready/enq_data : producer offers an entry, queue accepts it
//   deq_valid/deq_ready/deq_data : queue presents the head entry, consumer takes it
// master = producer/consumer side, slave = queue controller side.
interface sdq_queue_ctrl_if #(
   parameter int unsigned WIDTH = 64
) ();

   logic             enq_valid;
   logic             enq_ready;
   logic [WIDTH-1:0] enq_data;
   logic             deq_valid;
   logic             deq_ready;
   logic [WIDTH-1:0] deq_data;

   modport master (
      output enq_valid,
      output enq_data,
      output deq_ready,
      input  enq_ready,
      input  deq_valid,
      input  deq_data
   );

   modport slave (
      input  enq_valid,
      input  enq_data,
      input  deq_ready,
      output enq_ready,
      output deq_valid,
      output deq_data
   );

endinterface

// File: rtl/sdq_queue_ctrl.sv
// SDQ queue controller: FIFO bookkeeping (head/tail/count) in front of an
// external DEPTHxWIDTH SRAM macro with one write port and one same-cycle read port.
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   flush               : synchronous clear of the queue state
//   q (slave)           : enq/deq valid-ready handshakes and data
//   count, almost_full  : occupancy (0..DEPTH) and count >= AFULL_TH
//   mem_W0_*            : SRAM write port (addr/en/data)
//   mem_R0_*            : SRAM read port (addr/en out, data in, combinational)
module sdq_queue_ctrl #(
   parameter int unsigned DEPTH    = 17,
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned AFULL_TH = 14
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   sdq_queue_ctrl_if.slave     q,
   output logic [ADDR_W:0]     count,
   output logic                almost_full,
   output logic [ADDR_W-1:0]   mem_W0_addr,
   output logic                mem_W0_en,
   output logic [WIDTH-1:0]    mem_W0_data,
   output logic [ADDR_W-1:0]   mem_R0_addr,
   output logic                mem_R0_en,
   input  logic [WIDTH-1:0]    mem_R0_data
);

   localparam int unsigned     CNT_W    = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] r_head;
   logic [ADDR_W-1:0] r_tail;
   logic [CNT_W-1:0]  r_count;

   logic              w_full;
   logic              w_empty;
   logic              w_enq_ready;
   logic              w_deq_valid;
   logic              w_enq_fire;
   logic              w_deq_fire;
   logic [ADDR_W-1:0] w_head_inc;
   logic [ADDR_W-1:0] w_tail_inc;
   logic [CNT_W-1:0]  w_count_nxt;

   // Pointers wrap explicitly at DEPTH-1 since DEPTH need not be a power of two.
   function automatic logic [ADDR_W-1:0] f_ptr_inc(input logic [ADDR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
   endfunction

   // Occupancy decode and handshake qualification; reset/flush block both sides.
   assign w_full      = (r_count == CNT_W'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_enq_ready = !w_full  && !reset && !flush;
   assign w_deq_valid = !w_empty && !reset && !flush;
   assign w_enq_fire  = q.enq_valid && w_enq_ready;
   assign w_deq_fire  = w_deq_valid && q.deq_ready;
   assign w_head_inc  = f_ptr_inc(r_head);
   assign w_tail_inc  = f_ptr_inc(r_tail);

   // Count update: simultaneous enq and deq cancel out.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_enq_fire, w_deq_fire})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Queue state; reset and flush both clear it and win over handshakes.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq_fire) begin
            r_tail <= w_tail_inc;
         end
         if (w_deq_fire) begin
            r_head <= w_head_inc;
         end
         r_count <= w_count_nxt;
      end
   end

   // Handshake outputs; deq_data is gated so an undefined SRAM read never leaks.
   assign q.enq_ready  = w_enq_ready;
   assign q.deq_valid  = w_deq_valid;
   assign q.deq_data   = w_deq_valid ? mem_R0_data : '0;

   assign count        = r_count;
   assign almost_full  = (r_count >= CNT_W'(AFULL_TH));

   // SRAM ports: write at tail on enq, read head continuously while non-empty.
   assign mem_W0_en    = w_enq_fire;
   assign mem_W0_addr  = r_tail;
   assign mem_W0_data  = q.enq_data;
   assign mem_R0_en    = !w_empty;
   assign mem_R0_addr  = r_head;

endmodule

// File: tb/tb_sdq_queue_ctrl.sv
module tb_sdq_queue_ctrl;

   localparam int unsigned DEPTH    = 17;
   localparam int unsigned WIDTH    = 64;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned AFULL_TH = 14;
   localparam int          CW       = ADDR_W + 1;
   localparam int          DI       = int'(DEPTH);

   logic              clock = 1'b0;
   logic              reset;
   logic              flush;
   logic [ADDR_W:0]   count;
   logic              almost_full;
   logic [ADDR_W-1:0] mem_W0_addr;
   logic              mem_W0_en;
   logic [WIDTH-1:0]  mem_W0_data;
   logic [ADDR_W-1:0] mem_R0_addr;
   logic              mem_R0_en;
   logic [WIDTH-1:0]  mem_R0_data;

   sdq_queue_ctrl_if #(.WIDTH(WIDTH)) q_if ();

   sdq_queue_ctrl #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH)
   ) dut (
      .clock(clock), .reset(reset), .flush(flush), .q(q_if),
      .count(count), .almost_full(almost_full),
      .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data),
      .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data)
   );

   always #5 clock = ~clock;

   // SRAM macro model: synchronous write, combinational read.
   logic [WIDTH-1:0] mem [DEPTH];
   always @(posedge clock) begin
      if (mem_W0_en && (int'(mem_W0_addr) < DI)) mem[mem_W0_addr] <= mem_W0_data;
   end
   assign mem_R0_data = (mem_R0_en && (int'(mem_R0_addr) < DI)) ? mem[mem_R0_addr] : 'x;

   // Reference model: FIFO contents plus write/read positions modulo DEPTH.
   logic [WIDTH-1:0] m_q [$];
   int               m_wr = 0;
   int               m_rd = 0;
   int               n_cmp = 0;
   int               n_fail = 0;

   // Advance one clock edge, updating the model from the rules of the queue.
   task automatic tick();
      logic             ef, df;
      logic [WIDTH-1:0] d;
      ef = q_if.enq_valid && (m_q.size() != DI) && !reset && !flush;
      df = q_if.deq_ready && (m_q.size() != 0) && !reset && !flush;
      d  = q_if.enq_data;
      @(posedge clock);
      if (reset || flush) begin
         m_q.delete();
         m_wr = 0;
         m_rd = 0;
      end else begin
         if (df) begin
            void'(m_q.pop_front());
            m_rd = (m_rd + 1) % DI;
         end
         if (ef) begin
            m_q.push_back(d);
            m_wr = (m_wr + 1) % DI;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0;
      q_if.enq_valid = 1'b1; q_if.enq_data = 64'hDEAD_BEEF_0000_0001; q_if.deq_ready = 1'b1;
      tick();
      n_cmp++; if (q_if.enq_ready !== 1'b0) begin n_fail++; $display("FAIL rst_enq_ready got %b want 0", q_if.enq_ready); end
      n_cmp++; if (q_if.deq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_deq_valid got %b want 0", q_if.deq_valid); end
      n_cmp++; if (mem_W0_en !== 1'b0) begin n_fail++; $display("FAIL rst_w0_en got %b want 0", mem_W0_en); end
      n_cmp++; if (q_if.deq_data !== '0) begin n_fail++; $display("FAIL rst_deq_data got %h want 0", q_if.deq_data); end
      reset = 1'b0; q_if.enq_valid = 1'b0; q_if.deq_ready = 1'b0;
      #1;
      n_cmp++; if (q_if.enq_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_enq_ready got %b want 1", q_if.enq_ready); end
      n_cmp++; if (q_if.deq_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_deq_valid got %b want 0", q_if.deq_valid); end
      n_cmp++; if (count !== CW'(0)) begin n_fail++; $display("FAIL post_rst_count got %0d want 0", count); end
      n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL post_rst_afull got %b want 0", almost_full); end
   endtask

   task automatic test_single();
      q_if.enq_valid = 1'b1; q_if.enq_data = 64'hA5A5_0000_0000_0001;
      #1;
      n_cmp++; if (mem_W0_en !== 1'b1 || int'(mem_W0_addr) != m_wr) begin n_fail++; $display("FAIL single_write got en=%b addr=%0d want en=1 addr=%0d", mem_W0_en, mem_W0_addr, m_wr); end
      tick();
      q_if.enq_valid = 1'b0;
      #1;
      n_cmp++; if (q_if.deq_valid !== 1'b1) begin n_fail++; $display("FAIL single_deq_valid got %b want 1", q_if.deq_valid); end
      n_cmp++; if (q_if.deq_data !== m_q[0]) begin n_fail++; $display("FAIL single_deq_data got %h want %h", q_if.deq_data, m_q[0]); end
      n_cmp++; if (count !== CW'(m_q.size())) begin n_fail++; $display("FAIL single_count got %0d want %0d", count, m_q.size()); end
      q_if.deq_ready = 1'b1;
      tick();
      q_if.deq_ready = 1'b0;
      #1;
      n_cmp++; if (count !== CW'(0) || q_if.deq_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got count=%0d dv=%b want 0/0", count, q_if.deq_valid); end
   endtask

   task automatic test_fill_full();
      q_if.deq_ready = 1'b0;
      for (int i = 0; i < DI + 1; i++) begin
         q_if.enq_valid = 1'b1;
         q_if.enq_data  = {$urandom, $urandom};
         #1;
         n_cmp++; if (count !== CW'(m_q.size())) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, m_q.size()); end
         n_cmp++; if (almost_full !== (m_q.size() >= int'(AFULL_TH))) begin n_fail++; $display("FAIL fill_afull[%0d] got %b want %b", i, almost_full, m_q.size() >= int'(AFULL_TH)); end
         n_cmp++; if (q_if.enq_ready !== (m_q.size() != DI)) begin n_fail++; $display("FAIL fill_enq_ready[%0d] got %b want %b", i, q_if.enq_ready, m_q.size() != DI); end
         n_cmp++; if (mem_W0_en !== (m_q.size() != DI)) begin n_fail++; $display("FAIL fill_w0_en[%0d] got %b want %b", i, mem_W0_en, m_q.size() != DI); end
         if (m_q.size() != DI) begin
            n_cmp++; if (int'(mem_W0_addr) != m_wr) begin n_fail++; $display("FAIL fill_w0_addr[%0d] got %0d want %0d", i, mem_W0_addr, m_wr); end
         end
         tick();
      end
      #1;
      n_cmp++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count got %0d want %0d", count, DEPTH); end
      n_cmp++; if (q_if.enq_ready !== 1'b0 || mem_W0_en !== 1'b0) begin n_fail++; $display("FAIL full_block got rdy=%b en=%b want 0/0", q_if.enq_ready, mem_W0_en); end
      n_cmp++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL full_afull got %b want 1", almost_full); end
   endtask

   task automatic test_full_deq();
      q_if.enq_valid = 1'b1; q_if.deq_ready = 1'b1;
      #1;
      n_cmp++; if (q_if.enq_ready !== 1'b0) begin n_fail++; $display("FAIL fulldeq_enq_ready got %b want 0", q_if.enq_ready); end
      n_cmp++; if (q_if.deq_data !== m_q[0]) begin n_fail++; $display("FAIL fulldeq_data got %h want %h", q_if.deq_data, m_q[0]); end
      tick();
      q_if.enq_valid = 1'b0; q_if.deq_ready = 1'b0;
      #1;
      n_cmp++; if (count !== CW'(DEPTH - 1)) begin n_fail++; $display("FAIL fulldeq_count got %0d want %0d", count, DEPTH - 1); end
      n_cmp++; if (q_if.enq_ready !== 1'b1) begin n_fail++; $display("FAIL fulldeq_enq_ready_next got %b want 1", q_if.enq_ready); end
      q_if.deq_ready = 1'b1;
      for (int i = 0; i < DI + 2 && m_q.size() != 0; i++) begin
         #1;
         n_cmp++; if (q_if.deq_data !== m_q[0] || int'(mem_R0_addr) != m_rd) begin n_fail++; $display("FAIL drain[%0d] got %h@%0d want %h@%0d", i, q_if.deq_data, mem_R0_addr, m_q[0], m_rd); end
         tick();
      end
      q_if.deq_ready = 1'b0;
      #1;
      n_cmp++; if (count !== CW'(0)) begin n_fail++; $display("FAIL drain_count got %0d want 0", count); end
   endtask

   task automatic test_simul();
      int w0, r0;
      q_if.deq_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         q_if.enq_valid = 1'b1; q_if.enq_data = {$urandom, $urandom};
         tick();
      end
      q_if.enq_valid = 1'b1; q_if.deq_ready = 1'b1; q_if.enq_data = {$urandom, $urandom};
      w0 = m_wr; r0 = m_rd;
      #1;
      n_cmp++; if (int'(mem_W0_addr) != w0 || int'(mem_R0_addr) != r0) begin n_fail++; $display("FAIL simul_ptr_before got w=%0d r=%0d want w=%0d r=%0d", mem_W0_addr, mem_R0_addr, w0, r0); end
      tick();
      q_if.enq_valid = 1'b0; q_if.deq_ready = 1'b0;
      #1;
      n_cmp++; if (count !== CW'(5)) begin n_fail++; $display("FAIL simul_count got %0d want 5", count); end
      n_cmp++; if (int'(mem_W0_addr) != (w0 + 1) % DI || int'(mem_R0_addr) != (r0 + 1) % DI) begin n_fail++; $display("FAIL simul_ptr_after got w=%0d r=%0d want w=%0d r=%0d", mem_W0_addr, mem_R0_addr, (w0 + 1) % DI, (r0 + 1) % DI); end
      n_cmp++; if (q_if.deq_data !== m_q[0]) begin n_fail++; $display("FAIL simul_head got %h want %h", q_if.deq_data, m_q[0]); end
   endtask

   // Pass 0 clears with flush, pass 1 with reset, both at count 9 with enq_valid high.
   task automatic test_flush_reset();
      for (int pass = 0; pass < 2; pass++) begin
         q_if.deq_ready = 1'b0;
         for (int i = 0; i < DI && m_q.size() < 9; i++) begin
            q_if.enq_valid = 1'b1; q_if.enq_data = {$urandom, $urandom};
            tick();
         end
         q_if.enq_valid = 1'b1; q_if.deq_ready = 1'b1; q_if.enq_data = {$urandom, $urandom};
         if (pass == 0) flush = 1'b1; else reset = 1'b1;
         #1;
         n_cmp++; if (count !== CW'(9)) begin n_fail++; $display("FAIL clr%0d_pre_count got %0d want 9", pass, count); end
         n_cmp++; if (mem_W0_en !== 1'b0 || q_if.enq_ready !== 1'b0 || q_if.deq_valid !== 1'b0) begin n_fail++; $display("FAIL clr%0d_block got en=%b rdy=%b dv=%b want 0/0/0", pass, mem_W0_en, q_if.enq_ready, q_if.deq_valid); end
         n_cmp++; if (q_if.deq_data !== '0) begin n_fail++; $display("FAIL clr%0d_data_during got %h want 0", pass, q_if.deq_data); end
         tick();
         flush = 1'b0; reset = 1'b0; q_if.enq_valid = 1'b0; q_if.deq_ready = 1'b0;
         #1;
         n_cmp++; if (count !== CW'(0) || q_if.deq_valid !== 1'b0) begin n_fail++; $display("FAIL clr%0d_after got count=%0d dv=%b want 0/0", pass, count, q_if.deq_valid); end
         n_cmp++; if (q_if.deq_data !== '0) begin n_fail++; $display("FAIL clr%0d_data_after got %h want 0", pass, q_if.deq_data); end
         n_cmp++; if (mem_W0_addr !== '0 || mem_R0_addr !== '0) begin n_fail++; $display("FAIL clr%0d_ptrs got w=%0d r=%0d want 0/0", pass, mem_W0_addr, mem_R0_addr); end
      end
   endtask

   task automatic test_stream();
      int sent = 0, recv = 0, cycles = 0;
      int last_w = -1, last_r = -1, wraps_w = 0, wraps_r = 0;
      logic ef, df;
      while (recv < 40 && cycles < 3000) begin
         q_if.enq_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
         q_if.enq_data  = WIDTH'(sent);
         q_if.deq_ready = ($urandom_range(0, 2) != 0);
         #1;
         ef = q_if.enq_valid && (m_q.size() != DI);
         df = q_if.deq_ready && (m_q.size() != 0);
         n_cmp++; if (q_if.enq_ready !== (m_q.size() != DI) || q_if.deq_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL stream_hs[%0d] got rdy=%b dv=%b want %b/%b", cycles, q_if.enq_ready, q_if.deq_valid, m_q.size() != DI, m_q.size() != 0); end
         if (ef) begin
            n_cmp++; if (mem_W0_en !== 1'b1 || int'(mem_W0_addr) != m_wr) begin n_fail++; $display("FAIL stream_w[%0d] got en=%b addr=%0d want 1/%0d", sent, mem_W0_en, mem_W0_addr, m_wr); end
            if (last_w == DI - 1 && mem_W0_addr == '0) wraps_w++;
            last_w = int'(mem_W0_addr);
            sent++;
         end
         if (df) begin
            n_cmp++; if (q_if.deq_data !== WIDTH'(recv) || int'(mem_R0_addr) != m_rd) begin n_fail++; $display("FAIL stream_r[%0d] got %0d@%0d want %0d@%0d", recv, q_if.deq_data, mem_R0_addr, recv, m_rd); end
            if (last_r == DI - 1 && mem_R0_addr == '0) wraps_r++;
            last_r = int'(mem_R0_addr);
            recv++;
         end
         tick();
         cycles++;
      end
      q_if.enq_valid = 1'b0; q_if.deq_ready = 1'b0;
      n_cmp++; if (recv != 40) begin n_fail++; $display("FAIL stream_done got %0d entries in %0d cycles want 40", recv, cycles); end
      n_cmp++; if (wraps_w < 2 || wraps_r < 2) begin n_fail++; $display("FAIL stream_wraps got w=%0d r=%0d want >=2 each", wraps_w, wraps_r); end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      q_if.enq_valid = 1'b0; q_if.enq_data = '0; q_if.deq_ready = 1'b0;
      test_reset();
      test_single();
      test_fill_full();
      test_full_deq();
      test_simul();
      test_flush_reset();
      test_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sdq_queue_ctrl.md
SDQ_QUEUE_CTRL -- requirements
Module: sdq_queue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 17, number of queue entries (>=2).
REQ-002 SHALL have parameter WIDTH, default 64, data width in bits.
REQ-003 SHALL have parameter ADDR_W, default 5, memory address width, >= ceil(log2(DEPTH)).
REQ-004 SHALL have parameter AFULL_TH, default 14, almost-full threshold in entries.
REQ-005 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port flush  input  1  synchronous queue clear.
REQ-008 SHALL have port enq_valid  input  1  producer offers enq_data.
REQ-009 SHALL have port enq_ready  output  1  queue accepts an entry this cycle.
REQ-010 SHALL have port enq_data  input  WIDTH  entry to store.
REQ-011 SHALL have port deq_valid  output  1  head entry present on deq_data.
REQ-012 SHALL have port deq_ready  input  1  consumer takes the head entry.
REQ-013 SHALL have port deq_data  output  WIDTH  head entry.
REQ-014 SHALL have port count  output  ADDR_W+1  occupied entries, 0..DEPTH.
REQ-015 SHALL have port almost_full  output  1  count >= AFULL_TH.
REQ-016 SHALL have port mem_W0_addr / mem_W0_en / mem_W0_data  output  ADDR_W / 1 / WIDTH  write port to the external DEPTHxWIDTH SRAM macro.
REQ-017 SHALL have port mem_R0_addr / mem_R0_en  output  ADDR_W / 1  read port to the macro; mem_W0_clk and mem_R0_clk are tied to clock by the integrator.
REQ-018 SHALL have port mem_R0_data  input  WIDTH  combinational (same-cycle) read data from the macro; undefined when mem_R0_en=0.

Function
REQ-019 SHALL keep head pointer, tail pointer (each 0..DEPTH-1) and count registers.
REQ-020 SHALL define enq_fire = enq_valid & enq_ready and deq_fire = deq_valid & deq_ready.
REQ-021 SHALL drive enq_ready = (count != DEPTH) & !reset & !flush.
REQ-022 SHALL drive deq_valid = (count != 0) & !reset & !flush.
REQ-023 SHALL drive mem_W0_en = enq_fire, mem_W0_addr = tail, mem_W0_data = enq_data.
REQ-024 SHALL drive mem_R0_en = (count != 0), mem_R0_addr = head.
REQ-025 SHALL drive deq_data = mem_R0_data when deq_valid, else all zeros (never propagate X).
REQ-026 SHALL advance tail by 1 on enq_fire and head by 1 on deq_fire; pointer at DEPTH-1 wraps to 0 (non-power-of-two wrap, not bit truncation).
REQ-027 SHALL update count: +1 on enq_fire only, -1 on deq_fire only, unchanged on both or neither.
REQ-028 SHALL provide no enq-to-deq bypass: an entry written at edge N is visible on deq_data from cycle N+1 (latency 1).
REQ-029 SHALL, when full, deassert enq_ready even if deq_fire occurs that cycle (no same-cycle pass-through when full).
REQ-030 SHALL, when empty, accept enq while deq_valid=0; deq_ready is ignored when deq_valid=0.
REQ-031 SHALL, on flush, take priority over enq/deq: no memory write, head=tail=0, count=0 at next edge.
REQ-032 SHALL drive almost_full combinationally from count.
REQ-033 SHALL preserve FIFO order and data exactly across all wrap-arounds.

Reset
REQ-034 SHALL, while reset is high, force enq_ready=0, deq_valid=0, mem_W0_en=0, deq_data=0.
REQ-035 SHALL, at the first edge with reset high, set head=0, tail=0, count=0; reset has priority over flush and handshakes.
REQ-036 SHALL, in the first cycle after reset deasserts, present enq_ready=1, deq_valid=0, count=0, almost_full=0; memory contents need not be cleared.

Verification
REQ-037 SHALL cover: reset, enq 0xA5A5_0000_0000_0001 one cycle -> next cycle deq_valid=1, deq_data=0xA5A5_0000_0000_0001, count=1.
REQ-038 SHALL cover: 17 enqs with deq_ready=0 -> count=17, enq_ready=0, almost_full=1 from count 14; 18th enq_valid not written (mem_W0_en=0).
REQ-039 SHALL cover: full queue with enq_valid=1 and deq_ready=1 for one cycle -> one dequeue only, count=16, enq_ready=1 next cycle.
REQ-040 SHALL cover: 40 entries of incrementing data streamed with random valid/ready -> output sequence 0..39 in order, head/tail wrap 16->0 at least twice.
REQ-041 SHALL cover: count=5 with enq_fire and deq_fire same cycle -> count stays 5, both pointers advance.
REQ-042 SHALL cover: flush (and separately reset) asserted at count=9 together with enq_valid=1 -> no write, next cycle count=0, deq_valid=0, deq_data=0.
